// File: rtl/uart_packet_assembler.sv
// Byte-to-packet assembler: shifts received bytes into a PACKET_SIZE-bit packet (first byte in the MSBs),
// holds it for a valid/ready handshake and expires stale partial packets. Optional macro: UART_PAD_ON_TIMEOUT_EN.
module uart_packet_assembler #(
    parameter int unsigned PACKET_SIZE    = 184,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [7:0]                             byte_data,
    input  logic                                   byte_valid,
    output logic [PACKET_SIZE-1:0]                 packet,
    output logic                                   packet_valid,
    input  logic                                   packet_ready,
    output logic [$clog2(PACKET_SIZE/8+1)-1:0]     byte_count,
    output logic                                   overrun,
    output logic                                   timeout
);

    localparam int unsigned PACKET_BYTES = PACKET_SIZE / 8;
    localparam int unsigned CNT_W        = $clog2(PACKET_BYTES + 1);
    localparam int unsigned IDLE_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(PACKET_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

`ifdef UART_PAD_ON_TIMEOUT_EN
    typedef enum logic [1:0] {ST_FILL = 2'd0, ST_HOLD = 2'd1, ST_PAD = 2'd2} state_t;
`else
    typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;
`endif

    state_t                   state_q,   state_d;
    logic [PACKET_SIZE-1:0]   packet_q,  packet_d;
    logic                     valid_q,   valid_d;
    logic [CNT_W-1:0]         count_q,   count_d;
    logic [IDLE_W-1:0]        idle_q,    idle_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;
    logic                     shift_s;
    logic                     pad_shift_s;
    logic [7:0]               in_byte_s;

    // Next-state logic: state transitions first, then a shared shift-in path for accepted or pad bytes.
    always_comb begin
        state_d     = state_q;
        packet_d    = packet_q;
        valid_d     = valid_q;
        count_d     = count_q;
        idle_d      = idle_q;
        overrun_d   = overrun_q;
        timeout_d   = 1'b0;
        shift_s     = 1'b0;
        pad_shift_s = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (byte_valid) begin
                    // An arriving byte always beats a simultaneous expiry.
                    shift_s = 1'b1;
                    idle_d  = '0;
                end else if (count_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d    = '0;
                        timeout_d = 1'b1;
`ifdef UART_PAD_ON_TIMEOUT_EN
                        state_d   = ST_PAD;
`else
                        count_d   = '0;
`endif
                    end else begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            ST_HOLD: begin
                if (packet_ready) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    idle_d  = '0;
                    state_d = ST_FILL;
                    shift_s = byte_valid;
                end else if (byte_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
`ifdef UART_PAD_ON_TIMEOUT_EN
            ST_PAD: begin
                shift_s     = 1'b1;
                pad_shift_s = 1'b1;
                if (byte_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
`endif
            default: begin
                state_d = ST_FILL;
                valid_d = 1'b0;
                count_d = '0;
                idle_d  = '0;
            end
        endcase

        in_byte_s = pad_shift_s ? PAD_BYTE : byte_data;

        if (shift_s) begin
            packet_d = {packet_q[PACKET_SIZE-9:0], in_byte_s};
            count_d  = count_d + CNT_ONE;
            if (count_d == CNT_FULL) begin
                state_d = ST_HOLD;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            packet_d = packet_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FILL;
            packet_q  <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            idle_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            packet_q  <= packet_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign packet       = packet_q;
    assign packet_valid = valid_q;
    assign byte_count   = count_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule
